// File: rtl/location_bank_pkg.sv
// location_bank_pkg: shared types and helpers for the location bank
package location_bank_pkg;

  localparam int SIGNAL_BITS = 16;

  typedef logic [SIGNAL_BITS:0] loc_word_t;

  typedef enum logic {IDLE, SWEEP} sweep_state_e;

  // Bit n-1 is the sticky flag; the low n-1 bits add and clamp at all-ones.
  function automatic logic [31:0] sat_deposit(input logic [31:0] old_w, input logic [31:0] add_w, input int n);
    logic [31:0] mask, sum;
    mask = (32'd1 << (n - 1)) - 32'd1;
    sum = (old_w & mask) + (add_w & mask);
    return ((old_w | add_w) & (32'd1 << (n - 1))) | (sum > mask ? mask : sum);
  endfunction

  function automatic logic in_range(input int a, input int d);
    return a < d;
  endfunction

endpackage

// File: rtl/location_decay_ctrl.sv
// location_decay_ctrl: decay sweep FSM producing the sweep address and enable
module location_decay_ctrl
  import location_bank_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Clr,
  input  logic          Decay_Tick,
  output logic          Decay_Busy,
  output logic          Decay_Overrun,
  output logic          sweep_en,
  output logic [AW-1:0] sweep_addr
);

  sweep_state_e state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state <= IDLE;
      ptr <= '0;
      Decay_Overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      Decay_Overrun <= Decay_Tick && state == SWEEP;
    end
  end

  always_comb begin
    state_nxt = state == IDLE ? (Decay_Tick ? SWEEP : IDLE) : (ptr == AW'(DEPTH - 1) ? IDLE : SWEEP);
    ptr_nxt = state == IDLE ? '0 : ptr + AW'(1);
  end

  assign Decay_Busy = state == SWEEP;
  assign sweep_en = Decay_Busy;
  assign sweep_addr = ptr;

endmodule

// File: rtl/location_bank.sv
// location_bank: bank of signal cells with write/deposit, two read ports and decay sweep
module location_bank
  import location_bank_pkg::*;
#(
  parameter int N = SIGNAL_BITS + 1,
  parameter int DEPTH = 64,
  parameter int AW = $clog2(DEPTH),
  parameter int DECAY_STEP = 1
) (
  input  logic          Clk,
  input  logic          Clr,
  input  logic          Ld,
  input  logic          Ld_Mode,
  input  logic [AW-1:0] Ld_Addr,
  input  logic [N-1:0]  Data_In,
  input  logic          Lookup_Req,
  input  logic [AW-1:0] Lookup_Addr,
  output logic [N-1:0]  Lookup_Data,
  output logic          Lookup_Valid,
  input  logic [AW-1:0] Render_Addr,
  output logic [N-1:0]  Render_Data,
  input  logic          Decay_Tick,
  output logic          Decay_Busy,
  output logic          Decay_Overrun
);

  logic [N-1:0] mem [DEPTH];
  logic sweep_en, ld_ok;
  logic [AW-1:0] sweep_addr;
  logic [N-1:0] ld_word;
  logic [N-2:0] mag, mag_dec;

  location_decay_ctrl #(.DEPTH(DEPTH), .AW(AW)) u_decay (
    .Clk(Clk),
    .Clr(Clr),
    .Decay_Tick(Decay_Tick),
    .Decay_Busy(Decay_Busy),
    .Decay_Overrun(Decay_Overrun),
    .sweep_en(sweep_en),
    .sweep_addr(sweep_addr)
  );

  always_comb begin
    ld_ok = Ld && in_range(int'(Ld_Addr), DEPTH);
    ld_word = Ld_Mode ? N'(sat_deposit(32'(mem[Ld_Addr]), 32'(Data_In), N)) : Data_In;
    mag = mem[sweep_addr][N-2:0];
    mag_dec = mag > (N-1)'(DECAY_STEP) ? mag - (N-1)'(DECAY_STEP) : '0;
  end

  // Reads sample pre-edge contents; a write to the swept cell replaces its decay.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      Lookup_Data <= '0;
      Lookup_Valid <= 1'b0;
      Render_Data <= '0;
    end else begin
      if (sweep_en && !(ld_ok && Ld_Addr == sweep_addr)) mem[sweep_addr] <= {mem[sweep_addr][N-1], mag_dec};
      if (ld_ok) mem[Ld_Addr] <= ld_word;
      Lookup_Valid <= Lookup_Req;
      Lookup_Data <= Lookup_Req && in_range(int'(Lookup_Addr), DEPTH) ? mem[Lookup_Addr] : '0;
      Render_Data <= in_range(int'(Render_Addr), DEPTH) ? mem[Render_Addr] : '0;
    end
  end

endmodule

// File: tb/tb_location_bank.sv
// tb_location_bank: scoreboard bench for location_bank (N=17, DEPTH=48 leaves addresses 48..63 out of range)
module tb_location_bank;
  import location_bank_pkg::*;

  localparam int N = 17;
  localparam int DEPTH = 48;
  localparam int AW = 6;

  logic Clk = 0, Clr = 1, Ld = 0, Ld_Mode = 0, Lookup_Req = 0, Decay_Tick = 0;
  logic [AW-1:0] Ld_Addr = 0, Lookup_Addr = 0, Render_Addr = 0;
  logic [N-1:0] Data_In = 0;
  logic [N-1:0] Lookup_Data, Render_Data;
  logic Lookup_Valid, Decay_Busy, Decay_Overrun;

  int checks = 0, failures = 0;
  loc_word_t exp_q[$];
  logic req_d = 0;

  always #5 Clk = ~Clk;

  location_bank #(.N(N), .DEPTH(DEPTH), .AW(AW), .DECAY_STEP(1)) dut (
    .Clk(Clk),
    .Clr(Clr),
    .Ld(Ld),
    .Ld_Mode(Ld_Mode),
    .Ld_Addr(Ld_Addr),
    .Data_In(Data_In),
    .Lookup_Req(Lookup_Req),
    .Lookup_Addr(Lookup_Addr),
    .Lookup_Data(Lookup_Data),
    .Lookup_Valid(Lookup_Valid),
    .Render_Addr(Render_Addr),
    .Render_Data(Render_Data),
    .Decay_Tick(Decay_Tick),
    .Decay_Busy(Decay_Busy),
    .Decay_Overrun(Decay_Overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge Clk) req_d <= Lookup_Req && !Clr;

  always @(negedge Clk) begin
    chk("lk_valid", Lookup_Valid, req_d);
    if (Lookup_Valid) begin
      chk("lk_queue", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("lk_data", Lookup_Data, exp_q.pop_front());
    end else chk("lk_zero", Lookup_Data, 0);
  end

  task automatic wr(input logic m, input int a, input logic [N-1:0] d);
    Ld = 1; Ld_Mode = m; Ld_Addr = AW'(a); Data_In = d;
    @(negedge Clk);
    Ld = 0;
  endtask

  task automatic lk(input int a, input logic [N-1:0] e);
    Lookup_Req = 1; Lookup_Addr = AW'(a); exp_q.push_back(e);
    @(negedge Clk);
    Lookup_Req = 0;
  endtask

  task automatic rd(input int a, input logic [N-1:0] e);
    Render_Addr = AW'(a);
    @(negedge Clk);
    chk("render", Render_Data, e);
  endtask

  task automatic run_sweep(input int coll, input logic restart);
    int cnt = 0;
    Decay_Tick = 1;
    @(negedge Clk);
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i <= DEPTH) cnt += int'(Decay_Busy);
      if (i == 1) begin chk("ovr_start", Decay_Overrun, 1); Decay_Tick = 0; end
      if (i == 2) chk("ovr_clear", Decay_Overrun, 0);
      Ld = (i == coll); Ld_Mode = 0; Ld_Addr = AW'(coll); Data_In = 17'h00050;
      if (i == DEPTH - 1) Decay_Tick = 1;
      if (i == DEPTH) begin
        chk("ovr_end", Decay_Overrun, 1);
        chk("busy_end", Decay_Busy, 0);
        Decay_Tick = restart;
      end
      if (i == DEPTH + 1) begin chk("restart", Decay_Busy, restart); Decay_Tick = 0; end
      @(negedge Clk);
    end
    Ld = 0;
    chk("busy_len", cnt, DEPTH);
    for (int k = 0; k < 4 * DEPTH && Decay_Busy; k++) @(negedge Clk);
    chk("sweep_done", Decay_Busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge Clk);
    chk("rst_render", Render_Data, 0);
    chk("rst_busy", Decay_Busy, 0);
    chk("rst_ovr", Decay_Overrun, 0);
    Clr = 0;
    for (int a = 0; a < 64; a++) lk(a, 0);
    rd(0, 0);
    rd(47, 0);
    wr(0, 5, 17'h000FF);
    wr(1, 5, 17'h1FF10);
    lk(5, 17'h1FFFF);
    rd(5, 17'h1FFFF);
    wr(0, 9, 17'h00010);
    wr(1, 9, 17'h00020);
    lk(9, 17'h00030);
    wr(0, 50, 17'h12345);
    lk(50, 0);
    rd(50, 0);
    wr(0, 7, 17'h00011);
    Ld = 1; Ld_Mode = 0; Ld_Addr = 7; Data_In = 17'h00022;
    Lookup_Req = 1; Lookup_Addr = 7; exp_q.push_back(17'h00011);
    @(negedge Clk);
    Ld = 0; Lookup_Req = 0;
    lk(7, 17'h00022);
    wr(0, 3, 17'h10002);
    run_sweep(-1, 0);
    lk(3, 17'h10001);
    run_sweep(10, 0);
    lk(3, 17'h10000);
    lk(10, 17'h00050);
    run_sweep(-1, 1);
    lk(3, 17'h10000);
    lk(10, 17'h0004E);
    lk(5, 17'h1FFFB);
    lk(9, 17'h0002C);
    lk(7, 17'h0001E);
    Decay_Tick = 1;
    @(negedge Clk);
    Decay_Tick = 0;
    repeat (5) @(negedge Clk);
    chk("mid_busy", Decay_Busy, 1);
    Clr = 1; Decay_Tick = 1; Lookup_Req = 1; Lookup_Addr = 5; Render_Addr = 5;
    @(negedge Clk);
    Clr = 0; Decay_Tick = 0; Lookup_Req = 0;
    chk("clr_busy", Decay_Busy, 0);
    chk("clr_ovr", Decay_Overrun, 0);
    chk("clr_render", Render_Data, 0);
    chk("clr_valid", Lookup_Valid, 0);
    lk(5, 0);
    rd(9, 0);
    chk("clr_idle", Decay_Busy, 0);
    repeat (2) @(negedge Clk);
    chk("q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
